// File: rtl/pclk_phase_seq_if.sv
// Handshake and rail-drive bundle between the sequencer and its controller.
// Define PCLK_STALL_EN to add the stall input that freezes a running sequence.
interface pclk_phase_seq_if #(
  parameter int RAMP_BITS = 2
);
  logic                   start;
  logic                   stop;
`ifdef PCLK_STALL_EN
  logic                   stall;
`endif
  logic [4*RAMP_BITS-1:0] pclk_code;
  logic [7:0]             phase_state;
  logic [3:0]             eval;
  logic                   running;
  logic                   done;

  modport master (
`ifdef PCLK_STALL_EN
    output stall,
`endif
    output start, stop,
    input  pclk_code, phase_state, eval, running, done
  );

  modport slave (
`ifdef PCLK_STALL_EN
    input  stall,
`endif
    input  start, stop,
    output pclk_code, phase_state, eval, running, done
  );
endinterface

// File: rtl/pclk_phase_seq.sv
// Four-phase power-clock sequencer: quarter-period offset ramps per gate row.
// Optional feature macro PCLK_STALL_EN adds a stall input that freezes the sequence.
module pclk_phase_seq #(
  parameter int RAMP_BITS = 2,
  parameter int DIV       = 1
) (
  input  logic              clk,
  input  logic              rst,
  pclk_phase_seq_if.slave   bus
);

  localparam int CW = RAMP_BITS + 2;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_DRAINING = 2'b10
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [PW-1:0]        prediv, prediv_nxt;
  logic [3:0]           active, active_nxt;
  logic                 done_q, done_nxt;
  logic                 stalled;
  logic [1:0]           q_nxt;

  logic [1:0]           q;
  logic [RAMP_BITS-1:0] sub;
  logic [4*RAMP_BITS-1:0] code_w;
  logic [7:0]           pstate_w;
  logic [3:0]           eval_w;

`ifdef PCLK_STALL_EN
  assign stalled = bus.stall && (state != ST_STOPPED);
`else
  assign stalled = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_STOPPED;
      cnt    <= '0;
      prediv <= '0;
      active <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      prediv <= prediv_nxt;
      active <= active_nxt;
      done_q <= done_nxt;
    end
  end

  // Active bits only change on the step tick that crosses into a quadrant boundary,
  // so a phase is enabled or retired only between whole ramps.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    prediv_nxt = prediv;
    active_nxt = active;
    done_nxt   = 1'b0;
    q_nxt      = cnt[CW-1 -: 2];

    if (!stalled) begin
      case (state)
        ST_STOPPED: begin
          if (bus.start) begin
            state_nxt  = ST_RUNNING;
            cnt_nxt    = '0;
            prediv_nxt = '0;
            active_nxt = 4'b0001;
          end
        end

        ST_RUNNING, ST_DRAINING: begin
          if (prediv == PW'(DIV - 1)) begin
            prediv_nxt = '0;
            cnt_nxt    = cnt + CW'(1);
            q_nxt      = cnt_nxt[CW-1 -: 2];
            if (cnt_nxt[RAMP_BITS-1:0] == '0) begin
              for (int k = 0; k < 4; k++) begin
                if (q_nxt == 2'(k))
                  active_nxt[k] = (state == ST_RUNNING);
                else if (q_nxt == 2'(k + 3))
                  active_nxt[k] = active[k] && (state != ST_DRAINING);
              end
            end
          end else begin
            prediv_nxt = prediv + PW'(1);
          end

          if (state == ST_RUNNING) begin
            if (bus.stop)
              state_nxt = ST_DRAINING;
          end else begin
            if (active_nxt == 4'b0000) begin
              state_nxt = ST_STOPPED;
              done_nxt  = 1'b1;
            end else if (bus.start && !bus.stop) begin
              state_nxt = ST_RUNNING;
            end
          end
        end

        default: begin
          state_nxt  = ST_STOPPED;
          active_nxt = '0;
        end
      endcase
    end
  end

  assign q   = cnt[CW-1 -: 2];
  assign sub = cnt[RAMP_BITS-1:0];

  // Each phase sees the global quadrant rotated by its index; inactive phases rest at IDLE.
  always_comb begin
    code_w   = '0;
    pstate_w = 8'hFF;
    eval_w   = '0;
    for (int k = 0; k < 4; k++) begin
      if (active[k]) begin
        case (2'(q - 2'(k)))
          2'd0: begin
            pstate_w[2*k +: 2]              = 2'b00;
            code_w[k*RAMP_BITS +: RAMP_BITS] = sub;
          end
          2'd1: begin
            pstate_w[2*k +: 2]              = 2'b01;
            code_w[k*RAMP_BITS +: RAMP_BITS] = '1;
            eval_w[k]                        = 1'b1;
          end
          2'd2: begin
            pstate_w[2*k +: 2]              = 2'b10;
            code_w[k*RAMP_BITS +: RAMP_BITS] = ~sub;
          end
          default: begin
            pstate_w[2*k +: 2]              = 2'b11;
            code_w[k*RAMP_BITS +: RAMP_BITS] = '0;
          end
        endcase
      end
    end
  end

  assign bus.pclk_code   = code_w;
  assign bus.phase_state = pstate_w;
  assign bus.eval        = eval_w;
  assign bus.running     = (state == ST_RUNNING) || (state == ST_DRAINING);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_pclk_phase_seq.sv
// Directed bench for pclk_phase_seq: startup, steady state, drain, cancel, async reset, DIV=3.
// The stall check is included when PCLK_STALL_EN is defined.
module tb_pclk_phase_seq;
  localparam int RB = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic sawDone;

  int exp0 [16] = '{0, 1, 2, 3, 3, 3, 3, 3, 3, 2, 1, 0, 0, 0, 0, 0};

  pclk_phase_seq_if #(.RAMP_BITS(RB)) b1 ();
  pclk_phase_seq_if #(.RAMP_BITS(RB)) b3 ();

  pclk_phase_seq #(.RAMP_BITS(RB), .DIV(1)) dut (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  pclk_phase_seq #(.RAMP_BITS(RB), .DIV(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sp);
    b1.start = st;
    b1.stop  = sp;
  endtask

  function automatic logic [RB-1:0] code1(input int k);
    return b1.pclk_code[k*RB +: RB];
  endfunction

  function automatic logic [1:0] state1(input int k);
    return b1.phase_state[2*k +: 2];
  endfunction

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    b3.start = 1'b0;
    b3.stop  = 1'b0;
`ifdef PCLK_STALL_EN
    b1.stall = 1'b0;
    b3.stall = 1'b0;
`endif
    #3;
    checkOutput("rst_code",    32'(b1.pclk_code),   32'h0);
    checkOutput("rst_pstate",  32'(b1.phase_state), 32'hFF);
    checkOutput("rst_eval",    32'(b1.eval),        32'h0);
    checkOutput("rst_running", 32'(b1.running),     32'h0);
    checkOutput("rst_done",    32'(b1.done),        32'h0);
    #9 rst = 1'b0;
    nextCycle();

    // startup
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    for (int s = 0; s < 16; s++) begin
      checkOutput($sformatf("start_p0_code_s%0d", s), 32'(code1(0)), 32'(exp0[s]));
      checkOutput($sformatf("start_eval0_s%0d", s), 32'(b1.eval[0]), 32'((s >= 4 && s <= 7) ? 1 : 0));
      if (s < 4) begin
        checkOutput($sformatf("start_p1_idle_s%0d", s), 32'(state1(1)), 32'h3);
        checkOutput($sformatf("start_p1_code_s%0d", s), 32'(code1(1)), 32'h0);
      end
      if (s == 4)
        checkOutput("start_p1_rampup_s4", 32'(state1(1)), 32'h0);
      nextCycle();
    end

    // steady state at s=16
    checkOutput("steady_pstate",  32'(b1.phase_state), 32'h6C);
    checkOutput("steady_code",    32'(b1.pclk_code),   32'hF0);
    checkOutput("steady_running", 32'(b1.running),     32'h1);
    repeat (4) nextCycle();

    // drain with stop at s=20
    applyStimulus(1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    for (int s = 21; s < 32; s++) begin
      checkOutput($sformatf("drain_p2_noup_s%0d", s), 32'(state1(2) == 2'b00), 32'h0);
      checkOutput($sformatf("drain_p3_noup_s%0d", s), 32'(state1(3) == 2'b00), 32'h0);
      checkOutput($sformatf("drain_p0_noup_s%0d", s), 32'(state1(0) == 2'b00), 32'h0);
      if (s >= 28)
        checkOutput($sformatf("drain_p1_code_s%0d", s), 32'(code1(1)), 32'(31 - s));
      checkOutput($sformatf("drain_done_low_s%0d", s), 32'(b1.done), 32'h0);
      nextCycle();
    end
    checkOutput("drain_done_s32",    32'(b1.done),      32'h1);
    checkOutput("drain_running_s32", 32'(b1.running),   32'h0);
    checkOutput("drain_code_s32",    32'(b1.pclk_code), 32'h0);
    nextCycle();
    checkOutput("drain_done_s33",    32'(b1.done),      32'h0);

    // cancel a drain
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    repeat (20) nextCycle();
    applyStimulus(1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    sawDone = b1.done;
    nextCycle();
    applyStimulus(1'b1, 1'b0);
    sawDone = sawDone | b1.done;
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    for (int s = 23; s <= 37; s++) begin
      sawDone = sawDone | b1.done;
      if (s == 24) begin
        checkOutput("cancel_p2_up_s24",   32'(state1(2)), 32'h0);
        checkOutput("cancel_p2_code_s24", 32'(code1(2)),  32'h0);
      end
      if (s == 28)
        checkOutput("cancel_p3_up_s28", 32'(state1(3)), 32'h0);
      if (s < 37)
        nextCycle();
    end
    checkOutput("cancel_no_done", 32'(sawDone), 32'h0);

    // async reset mid-HOLD of phase0
    checkOutput("hold_p0_code",  32'(code1(0)),  32'h3);
    checkOutput("hold_p0_state", 32'(state1(0)), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_code",    32'(b1.pclk_code),   32'h0);
    checkOutput("async_pstate",  32'(b1.phase_state), 32'hFF);
    checkOutput("async_running", 32'(b1.running),     32'h0);
    #3 rst = 1'b0;
    nextCycle();

    // DIV=3: every code value lasts three cycles, period 48
    b3.start = 1'b1;
    nextCycle();
    b3.start = 1'b0;
    for (int c = 0; c < 52; c++) begin
      checkOutput($sformatf("div3_p0_code_c%0d", c), 32'(b3.pclk_code[RB-1:0]), 32'(exp0[(c / 3) % 16]));
      if (c == 48)
        checkOutput("div3_p0_rampup_c48", 32'(b3.phase_state[1:0]), 32'h0);
      nextCycle();
    end

    // start wins over stop while stopped
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    checkOutput("both_running",  32'(b1.running),  32'h1);
    checkOutput("both_p0_state", 32'(state1(0)),   32'h0);
    checkOutput("both_p0_code",  32'(code1(0)),    32'h0);
    nextCycle();
    nextCycle();
    checkOutput("both_p0_code_s2", 32'(code1(0)), 32'h2);

`ifdef PCLK_STALL_EN
    b1.stall = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      checkOutput($sformatf("stall_code_c%0d", c), 32'(code1(0)), 32'h2);
    end
    b1.stall = 1'b0;
    nextCycle();
    checkOutput("stall_release_code", 32'(code1(0)), 32'h3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
